serial_alu_sequencer: RTL and testbench



---
 rtl/serial_alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/subtract unit. One full_adder cell is reused over WIDTH
// cycles, LSB first, to produce a WIDTH-bit result and ARM-style NZCV flags.
// The core drives it through a start/busy/done handshake.

// Single-bit full adder cell, shared by every bit position of the serial datapath.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             carry_q, carry_d;
    logic             c_msb_q, c_msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] sh_next;

    // The only adder in the datapath: operates on the current LSBs and running carry.
    full_adder u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign sh_next  = {fa_sum, sh_q[WIDTH-1:1]};

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand latch, serial shift, and flag capture on the last bit.
    always_comb begin
        opa_d    = opa_q;
        opb_d    = opb_q;
        sh_d     = sh_q;
        carry_d  = carry_q;
        c_msb_d  = c_msb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                sh_d    = sh_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                // Carry out of bit WIDTH-2 is the carry into the MSB, needed for V.
                if (cnt_q == CW'(WIDTH - 2)) c_msb_d = fa_cout;
                if (last_bit) begin
                    result_d = sh_next;
                    n_d      = fa_sum;
                    z_d      = (sh_next == '0);
                    c_d      = fa_cout;
                    v_d      = c_msb_q ^ fa_cout;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sh_q     <= '0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sh_q     <= sh_d;
            carry_q  <= carry_d;
            c_msb_q  <= c_msb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign result = result_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer: one WIDTH=8 and one WIDTH=32
// instance share the stimulus bus; sel picks which one receives start and is observed.
module tb_serial_alu_sequencer;

    typedef struct {
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        sub_in = 1'b0;
    logic        sel    = 1'b0;
    logic [63:0] a_in   = '0;
    logic [63:0] b_in   = '0;

    logic        busy8, done8, n8, z8, c8, v8;
    logic [7:0]  result8;
    logic        busy32, done32, n32, z32, c32, v32;
    logic [31:0] result32;

    logic        obs_busy, obs_done, obs_n, obs_z, obs_c, obs_v;
    logic [63:0] obs_result;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_alu_sequencer #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start & ~sel),
        .sub    (sub_in),
        .a      (a_in[7:0]),
        .b      (b_in[7:0]),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .flag_n (n8),
        .flag_z (z8),
        .flag_c (c8),
        .flag_v (v8)
    );

    serial_alu_sequencer #(.WIDTH(32)) u_dut32 (
        .clk    (clk),
        .reset  (reset),
        .start  (start & sel),
        .sub    (sub_in),
        .a      (a_in[31:0]),
        .b      (b_in[31:0]),
        .busy   (busy32),
        .done   (done32),
        .result (result32),
        .flag_n (n32),
        .flag_z (z32),
        .flag_c (c32),
        .flag_v (v32)
    );

    always_comb begin
        obs_busy   = sel ? busy32 : busy8;
        obs_done   = sel ? done32 : done8;
        obs_result = sel ? {32'd0, result32} : {56'd0, result8};
        obs_n      = sel ? n32 : n8;
        obs_z      = sel ? z32 : z8;
        obs_c      = sel ? c32 : c8;
        obs_v      = sel ? v32 : v8;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: wide addition, overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic s);
        logic [64:0] mask, am, bm, full;
        exp_t e;
        mask  = (65'd1 << w) - 65'd1;
        am    = {1'b0, av} & mask;
        bm    = {1'b0, (s ? ~bv : bv)} & mask;
        full  = am + bm + {64'd0, s};
        e.res = full[63:0] & mask[63:0];
        e.c   = full[w];
        e.n   = e.res[w-1];
        e.z   = (e.res == 64'd0);
        e.v   = (am[w-1] == bm[w-1]) && (e.res[w-1] != am[w-1]);
        return e;
    endfunction

    task automatic run_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                          input logic s, input bit inject);
        int          lat = 0;
        int          busy_cnt = 0;
        int          restart = 0;
        bit          seen = 0;
        bit          hold_bad = 0;
        logic [63:0] prev_res;
        exp_t        e;
        @(negedge clk);
        prev_res = obs_result;
        a_in = av; b_in = bv; sub_in = s; start = 1'b1;
        exp_q.push_back(model(w, av, bv, s));
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; sub_in = ~s;
        for (int i = 1; i <= w + 4 && !seen; i++) begin
            @(negedge clk);
            if (obs_busy) busy_cnt++;
            if (obs_done) begin
                seen = 1;
                lat  = i;
            end else if (obs_result !== prev_res) begin
                hold_bad = 1;
            end
            start = inject && (i == 3 || i == w + 1);
            if (start) begin
                a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
            end
        end
        check("latency", 64'(lat), 64'(w + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(w));
        check("hold_result", 64'(hold_bad), 64'd0);
        e = exp_q.pop_front();
        if (seen) begin
            check("result", obs_result, e.res);
            check("flag_n", 64'(obs_n), 64'(e.n));
            check("flag_z", 64'(obs_z), 64'(e.z));
            check("flag_c", 64'(obs_c), 64'(e.c));
            check("flag_v", 64'(obs_v), 64'(e.v));
        end else begin
            check("done_seen", 64'd0, 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 64'(obs_done), 64'd0);
        check("busy_after", 64'(obs_busy), 64'd0);
        if (inject) begin
            for (int i = 0; i < w + 2; i++) begin
                @(negedge clk);
                if (obs_busy || obs_done) restart++;
            end
            check("ignored_start", 64'(restart), 64'd0);
            check("result_kept", obs_result, e.res);
        end
    endtask

    task automatic abort_op(input int w);
        int dones = 0;
        @(negedge clk);
        a_in = 64'h66; b_in = 64'h11; sub_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", 64'(obs_busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(obs_busy), 64'd0);
        check("abort_done", 64'(obs_done), 64'd0);
        check("abort_result", obs_result, 64'd0);
        check("abort_flags", 64'({obs_n, obs_z, obs_c, obs_v}), 64'd0);
        for (int i = 0; i < w + 4; i++) begin
            @(negedge clk);
            if (obs_done || obs_busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
    endtask

    initial begin
        logic [63:0] av, bv;
        logic        s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_result8", 64'(result8), 64'd0);
        check("rst_flags8", 64'({n8, z8, c8, v8}), 64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_result32", 64'(result32), 64'd0);
        check("rst_flags32", 64'({n32, z32, c32, v32}), 64'd0);
        reset = 1'b0;

        sel = 1'b0;
        run_op(8, 64'h7F, 64'h01, 1'b0, 0);
        run_op(8, 64'hFF, 64'h01, 1'b0, 0);
        run_op(8, 64'h05, 64'h05, 1'b1, 0);
        run_op(8, 64'h03, 64'h05, 1'b1, 0);
        run_op(8, 64'h80, 64'h01, 1'b1, 0);
        run_op(8, 64'h12, 64'h34, 1'b0, 1);
        abort_op(8);
        run_op(8, 64'hA5, 64'h5A, 1'b1, 0);

        sel = 1'b1;
        for (int i = 0; i < 200; i++) begin
            av = {32'd0, $urandom};
            bv = {32'd0, $urandom};
            s  = 1'($urandom_range(0, 1));
            case (i % 10)
                0: av = 64'h7FFF_FFFF;
                1: bv = av;
                2: av = 64'h8000_0000;
                3: bv = 64'hFFFF_FFFF;
                4: av = 64'd0;
                default: ;
            endcase
            run_op(32, av, bv, s, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
